// File: rtl/div_defs.sv
// Shared definitions for the iterative divider: state encoding, default width
// and bit-counter sizing.
package div_defs;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } div_state_e;

  localparam int unsigned DEF_WIDTH = 16;

  // Counter must hold the value WIDTH itself, hence the extra bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

  localparam int unsigned DEF_CNT_W = $clog2(DEF_WIDTH) + 1;

endpackage

// File: rtl/cla_sub_4.sv
// 4-bit borrow-lookahead subtractor slice: diff = a + ~b + cin, with group
// propagate/generate exported so slices can be chained by the parent.
module cla_sub_4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] diff_o,
  output logic       p_o,
  output logic       g_o
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  // Bit-level propagate/generate and lookahead carries within the slice.
  always_comb begin
    p    = a_i ^ ~b_i;
    g    = a_i & ~b_i;
    c[0] = cin_i;
    c[1] = g[0] | (p[0] & cin_i);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);
    diff_o = p ^ c;
    p_o    = &p;
    g_o    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end

endmodule

// File: rtl/seq_divider_16.sv
// Iterative unsigned restoring divider, one quotient bit per cycle, with a
// start/done handshake. Trial subtraction uses chained 4-bit lookahead slices.
import div_defs::*;

module seq_divider_16 #(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam int unsigned NS = WIDTH / 4 + 1;
  localparam int unsigned PW = 4 * NS;

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trial;
  logic [PW-1:0]    op_a, op_b, diff_full;
  logic [NS-1:0]    p_grp, g_grp;
  logic [NS:0]      carry;
  logic             borrow;
  logic             unused_bits;

  // Zero-pad the WIDTH+1 bit operands up to whole slices; the top slice
  // carries only bit WIDTH, its padded bits just propagate the carry.
  always_comb begin
    trial = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    op_a  = '0;
    op_b  = '0;
    op_a[WIDTH:0]   = trial;
    op_b[WIDTH-1:0] = d_q;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_slice
      cla_sub_4 u_slice (
        .a_i    (op_a[4*gi +: 4]),
        .b_i    (op_b[4*gi +: 4]),
        .cin_i  (carry[gi]),
        .diff_o (diff_full[4*gi +: 4]),
        .p_o    (p_grp[gi]),
        .g_o    (g_grp[gi])
      );
    end
  endgenerate

  // Ripple the slice group P/G into inter-slice carries; carry-in 1 completes two's complement.
  always_comb begin
    carry[0] = 1'b1;
    for (int unsigned i = 0; i < NS; i++) begin
      carry[i+1] = g_grp[i] | (p_grp[i] & carry[i]);
    end
  end

  assign borrow      = ~carry[NS];
  assign unused_bits = ^{diff_full[PW-1:WIDTH+1], r_q[WIDTH]};

  // Next-state, datapath and result-register update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          d_d   = divisor;
          q_d   = dividend;
          r_d   = '0;
          cnt_d = CW'(WIDTH);
          dbz_d = 1'b0;
          if (divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (borrow) begin
          r_d = trial;
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end else begin
          r_d = diff_full[WIDTH:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end
        cnt_d = cnt_q - CW'(1);
        // Last iteration: results are captured from this cycle's next values.
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          quo_d   = q_d;
          rem_d   = r_d[WIDTH-1:0];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_16.sv
// Self-checking bench for seq_divider_16: directed cases plus random operands
// checked against plain integer division.
module tb_seq_divider_16;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  seq_divider_16 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_quo"}, quotient, 0);
    check({tag, "_rem"}, remainder, 0);
    check({tag, "_dbz"}, div_by_zero, 0);
  endtask

  // Issue a/b in cycle 0 and follow it cycle by cycle. ign_cyc: cycle in which a
  // stray start (9/2) is driven; rst_cyc: cycle in which reset is asserted.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int unsigned ign_cyc, input int unsigned rst_cyc);
    logic [W-1:0] eq, er;
    if (b == 0) begin
      eq = '1;
      er = a;
    end else begin
      eq = a / b;
      er = a % b;
    end
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
    if (b == 0) begin
      check("dbz_done", done, 1);
      check("dbz_busy", busy, 0);
    end else begin
      for (int unsigned k = 1; k <= W; k++) begin
        check("run_busy", busy, 1);
        check("run_done", done, 0);
        if (k == ign_cyc) begin
          start = 1'b1; dividend = 16'd9; divisor = 16'd2;
        end
        if (k == rst_cyc) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          check_idle_zero("rst_mid");
          for (int unsigned j = 0; j < W + 2; j++) begin
            @(negedge clk);
            check("rst_no_done", done, 0);
            check("rst_no_busy", busy, 0);
          end
          return;
        end
        @(negedge clk);
        start = 1'b0;
      end
      check("done_pulse", done, 1);
      check("done_busy", busy, 0);
    end
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_by_zero", div_by_zero, (b == 0) ? 1 : 0);
    @(negedge clk);
    check("done_single", done, 0);
    check("idle_busy", busy, 0);
    check("hold_quo", quotient, eq);
    check("hold_rem", remainder, er);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle_zero("reset");

    run_div(16'd100, 16'd7, 0, 0);
    run_div(16'hFFFF, 16'd1, 0, 0);
    run_div(16'hFFFF, 16'hFFFF, 0, 0);
    run_div(16'd3, 16'd10, 0, 0);
    run_div(16'd0, 16'd5, 0, 0);
    run_div(16'd5, 16'd0, 0, 0);
    run_div(16'd100, 16'd7, 0, 0);
    run_div(16'd100, 16'd7, 5, 0);
    run_div(16'd1000, 16'd3, 0, 8);
    run_div(16'd1000, 16'd3, 0, 0);
    run_div(16'h8000, 16'h8001, 0, 0);

    // Reset and start together: the request is dropped.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; dividend = 16'd100; divisor = 16'd7;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check_idle_zero("rst_start");
    for (int unsigned j = 0; j < 3; j++) begin
      @(negedge clk);
      check("rst_start_done", done, 0);
      check("rst_start_busy", busy, 0);
    end

    for (int unsigned n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      case ($urandom_range(0, 9))
        0:       rb = '0;
        1, 2, 3: rb = W'($urandom_range(1, 15));
        4:       rb = W'($urandom_range(1, 255));
        default: rb = W'($urandom);
      endcase
      run_div(ra, rb, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
